f2c_dma_sched: RTL

- Sequences FPGA->CPU DMA into the host F2C ring buffer.
- Pulls 64-bit QWs from an upstream stream and packs them into 128-byte chunks (16 QWs). Each chunk goes out as a 32-DW MWr to the TLP transmitter.
- After each chunk, issues a 1-DW MWr posting the new write pointer to the host metrics buffer (MTR_BASE+0).
- Stalls when the ring is full against the host-supplied read pointer.

---
 rtl/f2c_dma_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/f2c_dma_sched.sv
// Purpose : FPGA->CPU DMA sequencer; packs upstream QWs into 128-byte MWr chunks for the host
//           F2C ring, then posts the new write pointer to the host metrics buffer.
// Latency : data is a combinational pass-through in SEND_DATA. A chunk needs 2 cycles from
//           IDLE to its header request, plus the grant wait.
// Backpressure: f2cReady_out follows txReady_in while a data TLP is open. Upstream is
//           stalled while the ring is full against rdPtr_in.
// Ports   : clk_in/reset_in (sync, active-high); dmaEnable_in, f2cBase_in, mtrBase_in and
//           rdPtr_in are host registers; f2cData/Valid/Ready form the upstream stream;
//           txReq/Grant/Addr/LenDW form the header side; txData/Valid/Ready form the payload side;
//           wrPtr_out is the ring write pointer.
// Option  : define F2C_TLP_COUNT_EN to add tlpCount_out and a 2-DW metrics write.
module f2c_dma_sched #(
    parameter int CHUNK_IDX_W  = 4,
    parameter int QW_PER_CHUNK = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   dmaEnable_in,
    input  logic [28:0]            f2cBase_in,
    input  logic [28:0]            mtrBase_in,
    input  logic [CHUNK_IDX_W-1:0] rdPtr_in,
    input  logic [63:0]            f2cData_in,
    input  logic                   f2cValid_in,
    output logic                   f2cReady_out,
    output logic                   txReq_out,
    input  logic                   txGrant_in,
    output logic [31:0]            txAddr_out,
    output logic [5:0]             txLenDW_out,
    output logic [63:0]            txData_out,
    output logic                   txValid_out,
    input  logic                   txReady_in,
`ifdef F2C_TLP_COUNT_EN
    output logic [31:0]            tlpCount_out,
`endif
    output logic [CHUNK_IDX_W-1:0] wrPtr_out
);

    localparam int BEAT_W = $clog2(QW_PER_CHUNK);
    localparam logic [BEAT_W-1:0]      BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0]      BEAT_LAST = BEAT_W'(QW_PER_CHUNK - 1);
    localparam logic [CHUNK_IDX_W-1:0] PTR_ONE   = CHUNK_IDX_W'(1);
`ifdef F2C_TLP_COUNT_EN
    localparam logic [5:0]             MTR_LEN   = 6'd2;
`else
    localparam logic [5:0]             MTR_LEN   = 6'd1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_REQ_DATA,
        S_SEND_DATA,
        S_REQ_MTR,
        S_SEND_MTR
    } state_t;

    state_t                   state;
    logic [CHUNK_IDX_W-1:0]   wr_ptr;
    logic [BEAT_W-1:0]        beat_cnt;
    logic                     tx_req;
    logic [31:0]              tx_addr;
    logic [5:0]               tx_len;

    logic [CHUNK_IDX_W-1:0]   wr_ptr_inc;
    logic                     ring_full;
    logic [31:0]              data_addr;
    logic                     beat_fire;
    logic [63:0]              mtr_payload;

    assign wr_ptr_inc = wr_ptr + PTR_ONE;
    // One slot stays empty so that a full ring can be told apart from an empty one.
    // rdPtr_in is used live, not registered.
    assign ring_full  = (wr_ptr_inc == rdPtr_in);
    // 32-bit wrapping sum: a ring placed near the top of memory wraps through address 0.
    assign data_addr  = {f2cBase_in, 3'b000} + (32'(wr_ptr) << 7);
    assign beat_fire  = f2cValid_in && txReady_in;

`ifdef F2C_TLP_COUNT_EN
    logic [31:0] tlp_cnt;
    logic [31:0] tlp_cnt_next;
    assign tlp_cnt_next = tlp_cnt + 32'd1;
    // wr_ptr already holds the post-increment value while in SEND_MTR.
    assign mtr_payload  = {tlp_cnt_next, 32'(wr_ptr)};
    assign tlpCount_out = tlp_cnt;
`else
    assign mtr_payload  = {32'h0, 32'(wr_ptr)};
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            beat_cnt <= '0;
            tx_req   <= 1'b0;
            tx_addr  <= '0;
            tx_len   <= '0;
`ifdef F2C_TLP_COUNT_EN
            tlp_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!dmaEnable_in) begin
                        wr_ptr  <= '0;
`ifdef F2C_TLP_COUNT_EN
                        tlp_cnt <= '0;
`endif
                    end else if (f2cValid_in) begin
                        state <= S_WAIT_SPACE;
                    end
                end
                S_WAIT_SPACE: begin
                    // Only state where a disable takes effect before a TLP starts.
                    if (!dmaEnable_in) begin
                        state  <= S_IDLE;
                        wr_ptr <= '0;
                    end else if (!ring_full) begin
                        state   <= S_REQ_DATA;
                        tx_req  <= 1'b1;
                        tx_addr <= data_addr;
                        tx_len  <= 6'd32;
                    end
                end
                S_REQ_DATA: begin
                    if (txGrant_in) begin
                        state  <= S_SEND_DATA;
                        tx_req <= 1'b0;
                    end
                end
                S_SEND_DATA: begin
                    if (beat_fire) begin
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            wr_ptr   <= wr_ptr_inc;
                            state    <= S_REQ_MTR;
                            tx_req   <= 1'b1;
                            tx_addr  <= {mtrBase_in, 3'b000};
                            tx_len   <= MTR_LEN;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_ONE;
                        end
                    end
                end
                S_REQ_MTR: begin
                    if (txGrant_in) begin
                        state  <= S_SEND_MTR;
                        tx_req <= 1'b0;
                    end
                end
                S_SEND_MTR: begin
                    if (txReady_in) begin
                        state   <= S_IDLE;
`ifdef F2C_TLP_COUNT_EN
                        tlp_cnt <= tlp_cnt_next;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Payload path is combinational, so an upstream stall shows up as an immediate txValid_out drop.
    always_comb begin
        f2cReady_out = 1'b0;
        txValid_out  = 1'b0;
        txData_out   = '0;
        case (state)
            S_SEND_DATA: begin
                f2cReady_out = txReady_in;
                txValid_out  = f2cValid_in;
                txData_out   = f2cData_in;
            end
            S_SEND_MTR: begin
                txValid_out  = 1'b1;
                txData_out   = mtr_payload;
            end
            default: ;
        endcase
    end

    assign txReq_out   = tx_req;
    assign txAddr_out  = tx_addr;
    assign txLenDW_out = tx_len;
    assign wrPtr_out   = wr_ptr;

endmodule
